// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg: shared state encoding and size defaults
// for the serial pattern generator.
package seq_gen_pkg;

  localparam int MAX_LEN_DEF = 16;
  localparam int GAP_W_DEF   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/seq_pattern_gen_if.sv
// seq_pattern_gen_if: descriptor load handshake bundle
// between a pattern producer and the generator.
interface seq_pattern_gen_if #(
  parameter int MAX_LEN = 16,
  parameter int GAP_W   = 4
);

  localparam int LW = $clog2(MAX_LEN + 1);

  logic               load_valid;
  logic               load_ready;
  logic [MAX_LEN-1:0] load_pattern;
  logic [LW-1:0]      load_len;
  logic [GAP_W-1:0]   load_gap;
  logic [7:0]         load_reps;

  modport master (
    output load_valid,
    output load_pattern,
    output load_len,
    output load_gap,
    output load_reps,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_pattern,
    input  load_len,
    input  load_gap,
    input  load_reps,
    output load_ready
  );

endinterface

// File: rtl/seq_shift_reg.sv
// seq_shift_reg: loadable PISO register; the pattern is
// left-aligned by length so the MSB always leads.
module seq_shift_reg #(
  parameter int MAX_LEN = 16,
  parameter int LW      = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               shift,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LW-1:0]      len,
  output logic               out
);

  logic [MAX_LEN-1:0] data;
  logic [LW-1:0]      align;

  assign align = LW'(MAX_LEN) - len;

  // load aligns bit len-1 to the top; shift moves the next bit up
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
    end else if (load) begin
      data <= pattern << align;
    end else if (shift) begin
      data <= data << 1;
    end
  end

  assign out = data[MAX_LEN-1];

endmodule

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serial pattern generator, MSB-first.
// SEQ_GEN_REPEAT_EN adds repeated passes with idle gaps.
module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int GAP_W   = GAP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              abort,
  seq_pattern_gen_if.slave  load,
  output logic              dout,
  output logic              dout_valid,
  output logic              busy,
  output logic              done
);

  localparam int LW = $clog2(MAX_LEN + 1);

  state_t             state;
  logic [LW-1:0]      cnt;
  logic [LW-1:0]      len_c;
  logic               take;
  logic               sh_load;
  logic               sh_shift;
  logic               sh_out;
  logic [MAX_LEN-1:0] sh_pat;
  logic [LW-1:0]      sh_len;

  assign len_c = (load.load_len > LW'(MAX_LEN))
               ? LW'(MAX_LEN) : load.load_len;

  assign load.load_ready = (state == IDLE);
  assign take = (state == IDLE) && load.load_valid;
  assign sh_shift = (state == SHIFT) && (cnt != '0);

`ifdef SEQ_GEN_REPEAT_EN
  logic [MAX_LEN-1:0] pat_q;
  logic [LW-1:0]      len_q;
  logic [7:0]         pass_q;
  logic [GAP_W-1:0]   gap_q;
  logic [GAP_W-1:0]   gap_cnt;
  logic               reload;

  assign reload = (state == SHIFT) && (cnt == '0)
               && (pass_q != '0);
  assign sh_load = take || reload;
  assign sh_pat = take ? load.load_pattern : pat_q;
  assign sh_len = take ? len_c : len_q;

  // pass and gap bookkeeping, saturating at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q   <= '0;
      len_q   <= '0;
      pass_q  <= '0;
      gap_q   <= '0;
      gap_cnt <= '0;
    end else if (take) begin
      pat_q   <= load.load_pattern;
      len_q   <= len_c;
      pass_q  <= load.load_reps;
      gap_q   <= load.load_gap;
    end else if (reload) begin
      pass_q  <= pass_q - 8'd1;
      if (gap_q != '0) gap_cnt <= gap_q - 1'b1;
    end else if (state == GAP && gap_cnt != '0) begin
      gap_cnt <= gap_cnt - 1'b1;
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg = ^{load.load_gap, load.load_reps};
  assign sh_load = take;
  assign sh_pat = load.load_pattern;
  assign sh_len = len_c;
`endif

  seq_shift_reg #(
    .MAX_LEN (MAX_LEN),
    .LW      (LW)
  ) u_shreg (
    .clk     (clk),
    .rst     (rst),
    .load    (sh_load),
    .shift   (sh_shift),
    .pattern (sh_pat),
    .len     (sh_len),
    .out     (sh_out)
  );

  // control FSM: reset beats abort, abort beats completion
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (abort && state != IDLE) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (take) begin
            cnt   <= len_c - 1'b1;
            state <= (len_c == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
`ifdef SEQ_GEN_REPEAT_EN
          end else if (pass_q != '0) begin
            cnt   <= len_q - 1'b1;
            state <= (gap_q != '0) ? GAP : SHIFT;
`endif
          end else begin
            state <= DONE;
          end
        end
`ifdef SEQ_GEN_REPEAT_EN
        GAP: begin
          if (gap_cnt == '0) state <= SHIFT;
        end
`endif
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign dout_valid = (state == SHIFT);
  assign dout = dout_valid & sh_out;
  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb_seq_pattern_gen: directed checks of the pattern
// generator, including a 101 detector on the output.
module tb_seq_pattern_gen;

  logic clk = 1'b0;
  logic rst;
  logic abort;
  logic dout;
  logic dout_valid;
  logic busy;
  logic done;

  int total = 0;
  int bad = 0;

  logic [1:0] hist;
  logic       det;

  seq_pattern_gen_if #(.MAX_LEN(16), .GAP_W(4)) lif ();

  seq_pattern_gen #(
    .MAX_LEN (16),
    .GAP_W   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .abort      (abort),
    .load       (lif),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // downstream 101 detector, restarts on every burst
  always @(posedge clk) begin
    if (rst || !dout_valid) hist <= 2'b00;
    else hist <= {hist[0], dout};
  end
  assign det = dout_valid & dout & (hist == 2'b10);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic dv,
                      input logic d, input logic dn,
                      input logic rdy);
    chk({tag, ".dv"}, 32'(dout_valid), 32'(dv));
    chk({tag, ".dout"}, 32'(dout), 32'(d));
    chk({tag, ".done"}, 32'(done), 32'(dn));
    chk({tag, ".rdy"}, 32'(lif.load_ready), 32'(rdy));
  endtask

  // offer in cycle T, return at T+1 with inputs scrambled
  task automatic offer(input logic [15:0] pat,
                       input logic [4:0] len,
                       input logic [3:0] gap,
                       input logic [7:0] reps);
    lif.load_valid   = 1'b1;
    lif.load_pattern = pat;
    lif.load_len     = len;
    lif.load_gap     = gap;
    lif.load_reps    = reps;
    tick();
    lif.load_valid   = 1'b0;
    lif.load_pattern = ~pat;
    lif.load_len     = 5'd1;
    lif.load_gap     = 4'd0;
    lif.load_reps    = 8'd0;
  endtask

  initial begin
    logic [15:0] w;
    logic [11:0] exp_dv;
    logic [11:0] exp_d;
    rst = 1'b1;
    abort = 1'b0;
    lif.load_valid = 1'b0;
    lif.load_pattern = '0;
    lif.load_len = '0;
    lif.load_gap = '0;
    lif.load_reps = '0;
    tick();
    tick();
    rst = 1'b0;

    outs("reset", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset.busy", 32'(busy), 32'd0);

    // 101, len 3
    offer(16'b101, 5'd3, 4'd0, 8'd0);
    outs("p101.b1", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("p101.busy", 32'(busy), 32'd1);
    tick();
    outs("p101.b2", 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    outs("p101.b3", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    outs("p101.done", 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    outs("p101.idle", 1'b0, 1'b0, 1'b0, 1'b1);

    // len 5 with junk above the length: 10110
    offer(16'hFF16, 5'd5, 4'd0, 8'd0);
    w = '0;
    for (int i = 0; i < 5; i++) begin
      chk("len5.dv", 32'(dout_valid), 32'd1);
      w = {w[14:0], dout};
      tick();
    end
    chk("len5.bits", 32'(w), 32'h16);
    chk("len5.done", 32'(done), 32'd1);
    tick();

    // closed loop: 101101001 into the detector
    offer(16'b1_0110_1001, 5'd9, 4'd0, 8'd0);
    for (int i = 1; i <= 9; i++) begin
      chk("det.pulse", 32'(det), 32'((i == 3) || (i == 6)));
      tick();
    end
    chk("det.done", 32'(done), 32'd1);
    tick();

    // len 0: done at T+1, nothing valid
    offer(16'hFFFF, 5'd0, 4'd0, 8'd0);
    outs("len0.done", 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    outs("len0.idle", 1'b0, 1'b0, 1'b0, 1'b1);

    // len 20 clamps to 16
    offer(16'hA5C3, 5'd20, 4'd0, 8'd0);
    w = '0;
    for (int i = 0; i < 16; i++) begin
      chk("len20.dv", 32'(dout_valid), 32'd1);
      w = {w[14:0], dout};
      tick();
    end
    chk("len20.bits", 32'(w), 32'hA5C3);
    outs("len20.done", 1'b0, 1'b0, 1'b1, 1'b0);
    tick();

    // abort at 2nd bit of len 8
    offer(16'h00FF, 5'd8, 4'd0, 8'd0);
    tick();
    chk("abort.b2", 32'(dout_valid), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    outs("abort.next", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("abort.busy", 32'(busy), 32'd0);
    tick();
    chk("abort.nodone", 32'(done), 32'd0);

    // abort on the last bit wins over completion
    offer(16'b11, 5'd2, 4'd0, 8'd0);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    outs("abortlast", 1'b0, 1'b0, 1'b0, 1'b1);

    // abort in IDLE is ignored, load still accepted
    abort = 1'b1;
    offer(16'b1, 5'd1, 4'd0, 8'd0);
    abort = 1'b0;
    outs("idleabort.b1", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    outs("idleabort.done", 1'b0, 1'b0, 1'b1, 1'b0);
    tick();

    // reset mid-SHIFT with a competing load
    offer(16'h00AA, 5'd8, 4'd0, 8'd0);
    tick();
    rst = 1'b1;
    lif.load_valid = 1'b1;
    lif.load_len = 5'd4;
    tick();
    rst = 1'b0;
    lif.load_valid = 1'b0;
    outs("rstmid", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rstmid.busy", 32'(busy), 32'd0);
    tick();
    chk("rstmid.noload", 32'(busy), 32'd0);

`ifdef SEQ_GEN_REPEAT_EN
    // 10 x3 passes, gap 3: done 12 cycles after T+1
    exp_dv = 12'b1100_0110_0011;
    exp_d  = 12'b1000_0100_0010;
    offer(16'b10, 5'd2, 4'd3, 8'd2);
    for (int i = 11; i >= 0; i--) begin
      chk("rep.dv", 32'(dout_valid), 32'(exp_dv[i]));
      chk("rep.dout", 32'(dout), 32'(exp_d[i]));
      chk("rep.nodone", 32'(done), 32'd0);
      tick();
    end
    outs("rep.done", 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    outs("rep.idle", 1'b0, 1'b0, 1'b0, 1'b1);
`else
    // reps and gap are ignored: single pass
    exp_dv = 12'b0;
    exp_d  = 12'b0;
    offer(16'b10, 5'd2, 4'd3, 8'd2);
    outs("norep.b1", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    outs("norep.b2", 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    outs("norep.done", 1'b0, exp_d[0], 1'b1, 1'b0);
    tick();
    outs("norep.idle", exp_dv[0], 1'b0, 1'b0, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_pattern_gen.md
SEQ_PATTERN_GEN -- requirements
Module: seq_pattern_gen

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16, the maximum pattern length in bits.
REQ-002 SHALL have parameter GAP_W, default 4, the width of the inter-pass gap count.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port abort, input, 1 bit: synchronous request to cancel the current transmission.
REQ-006 SHALL have port load_valid, input, 1 bit: a pattern descriptor is offered.
REQ-007 SHALL have port load_ready, output, 1 bit: the block can accept a descriptor.
REQ-008 SHALL have port load_pattern, input, MAX_LEN bits: the pattern bits, right-aligned.
REQ-009 SHALL have port load_len, input, $clog2(MAX_LEN+1) bits: the number of pattern bits to send.
REQ-010 SHALL have port load_gap, input, GAP_W bits: the number of idle cycles between passes.
REQ-011 SHALL have port load_reps, input, 8 bits: the extra pass count; this port is always present.
REQ-012 SHALL have port dout, output, 1 bit: the serial bit stream, for a downstream serial detector din.
REQ-013 SHALL have port dout_valid, output, 1 bit: dout carries a pattern bit this cycle.
REQ-014 SHALL have port busy, output, 1 bit: the block is not in the IDLE state.
REQ-015 SHALL have port done, output, 1 bit: a one-cycle pulse on normal completion.

Function
REQ-016 SHALL accept a descriptor on the cycle where load_valid && load_ready; load_ready SHALL be 1 only in IDLE.
REQ-017 SHALL serialize MSB-first within the length: bit load_len-1 first, bit 0 last.
REQ-018 SHALL produce its outputs from registers: for a handshake accepted at cycle T, bits appear at T+1 through T+len with dout_valid=1.
REQ-019 SHALL drive dout=0 whenever dout_valid=0.
REQ-020 SHALL implement the FSM states IDLE, SHIFT, GAP and DONE.
REQ-021 SHALL follow these transitions:
- IDLE->SHIFT on handshake;
- SHIFT->GAP after the last bit if passes remain and gap>0;
- SHIFT->SHIFT (back-to-back reload) if passes remain and gap=0;
- SHIFT->DONE after the last bit of the final pass;
- GAP->SHIFT after load_gap idle cycles;
- DONE->IDLE always.
REQ-022 SHALL assert done=1 only in DONE, for exactly one cycle, at T+len+1 for a single pass; load_ready SHALL return at T+len+2.
REQ-023 SHALL treat load_len=0 as: accept the descriptor, emit no bits, go IDLE->DONE at T+1.
REQ-024 SHALL clamp load_len>MAX_LEN to MAX_LEN.
REQ-025 SHALL capture pattern, length, gap and reps at the handshake; input changes after acceptance SHALL have no effect.
REQ-026 SHALL go to IDLE on the next edge when abort=1 in any non-IDLE state, with no done pulse and dout_valid=0 on that cycle.
REQ-027 SHALL give abort priority over completion when both occur in the same cycle.
REQ-028 SHALL ignore abort in IDLE; a load_valid in the same cycle as abort SHALL still be accepted.
REQ-029 SHALL hold the pass counter and gap counter at widths 8 and GAP_W, with no wrap-around past the programmed values.

Reset
REQ-030 SHALL, with rst=1 at an edge, go to IDLE with dout=0, dout_valid=0, done=0, busy=0, load_ready=1 on the following cycle.
REQ-031 SHALL treat reset mid-transmission as an abort without a done pulse; reset SHALL take priority over abort and load.

Configuration
REQ-032 SHALL use the macro SEQ_GEN_REPEAT_EN.
REQ-033 SHALL, when SEQ_GEN_REPEAT_EN is defined, send the pattern load_reps+1 times, separated by load_gap idle cycles.
REQ-034 SHALL, when SEQ_GEN_REPEAT_EN is undefined, send exactly one pass; load_reps and load_gap SHALL be ignored and the GAP state and pass counter SHALL be absent.

Structure
REQ-035 SHALL place the state enum (IDLE, SHIFT, GAP, DONE) and the default MAX_LEN/GAP_W constants in package seq_gen_pkg.
REQ-036 SHALL use one sub-module, seq_shift_reg: a loadable MAX_LEN-bit parallel-in serial-out register with load, shift, and an MSB-select by length.

Verification
REQ-037 SHALL cover this scenario: pattern=0b101, len=3, single pass -> dout 1,0,1 at T+1..T+3, done at T+4, load_ready at T+5.
REQ-038 SHALL cover this closed-loop scenario: output connected to the 101 serial detector, pattern=0b101101001, len=9 -> detector pulses aligned with the 3rd and 6th bits.
REQ-039 SHALL cover this scenario with the macro defined: pattern=0b10, len=2, reps=2, gap=3 -> bits 1,0, 3 idle cycles, 1,0, 3 idle cycles, 1,0, then done; 12 cycles from T+1 to done.
REQ-040 SHALL cover this scenario: abort at the 2nd bit of len=8 -> dout_valid=0 on the next cycle, no done, load_ready=1 after.
REQ-041 SHALL cover this scenario: len=0 -> done at T+1 with no valid bits; len=20 with MAX_LEN=16 -> 16 bits sent.
REQ-042 SHALL cover this scenario: rst asserted mid-SHIFT together with load_valid -> IDLE next cycle with all outputs at reset values and the load not accepted.
